// File: rtl/char_req_arbiter_if.sv
// Issue-side bus between char_req_arbiter and lcd_show_char.
// The arbiter is the master: it drives the one-cycle show_char_flag
// together with the character fields and receives show_char_done back.
interface char_req_arbiter_if #(
    parameter int X_W     = 9,
    parameter int Y_W     = 9,
    parameter int COLOR_W = 16
);
    logic               show_char_flag;
    logic [6:0]         ascii_num;
    logic [X_W-1:0]     start_x;
    logic [Y_W-1:0]     start_y;
    logic               en_size;
    logic [COLOR_W-1:0] front_color;
    logic [COLOR_W-1:0] background_color;
    logic               show_char_done;

    modport master (
        output show_char_flag,
        output ascii_num,
        output start_x,
        output start_y,
        output en_size,
        output front_color,
        output background_color,
        input  show_char_done
    );

    modport slave (
        input  show_char_flag,
        input  ascii_num,
        input  start_x,
        input  start_y,
        input  en_size,
        input  front_color,
        input  background_color,
        output show_char_done
    );
endinterface

// File: rtl/char_req_arbiter.sv
// char_req_arbiter: round-robin arbiter collecting character-draw requests
// from NUM_CH display sources into a shared FIFO, then issuing them one at
// a time to lcd_show_char over a flag/done handshake.
// Optional build macro CHAR_ARB_TIMEOUT_EN adds a WAIT watchdog that gives
// up after TIMEOUT_CYC cycles without show_char_done and pulses timeout_err.
module char_req_arbiter #(
    parameter int NUM_CH      = 4,
    parameter int FIFO_DEPTH  = 8,
    parameter int X_W         = 9,
    parameter int Y_W         = 9,
    parameter int COLOR_W     = 16,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst,
    input  logic                        init_done,
    input  logic [NUM_CH-1:0]           ch_mask,
    input  logic [NUM_CH-1:0]           ch_req,
    output logic [NUM_CH-1:0]           ch_ack,
    input  logic [NUM_CH*7-1:0]         ch_ascii,
    input  logic [NUM_CH*X_W-1:0]       ch_start_x,
    input  logic [NUM_CH*Y_W-1:0]       ch_start_y,
    input  logic [NUM_CH-1:0]           ch_en_size,
    input  logic [NUM_CH*COLOR_W-1:0]   ch_front_color,
    input  logic [NUM_CH*COLOR_W-1:0]   ch_background_color,
    input  logic                        flush,
    char_req_arbiter_if.master          lcd,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        busy,
    output logic                        timeout_err
);

    localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W   = PTR_W + 1;
    localparam int ENTRY_W = 7 + X_W + Y_W + 1 + 2 * COLOR_W;

    localparam logic [IDX_W-1:0] RR_RESET = IDX_W'(NUM_CH - 1);
    localparam logic [IDX_W:0]   NUM_CH_W = (IDX_W + 1)'(NUM_CH);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     count_q, count_d;
    logic [ENTRY_W-1:0]   fifo_mem_q [FIFO_DEPTH];
    logic [ENTRY_W-1:0]   fifo_mem_d [FIFO_DEPTH];
    logic [ENTRY_W-1:0]   issued_q, issued_d;

    logic [NUM_CH-1:0]    eligible;
    logic [IDX_W:0]       cand;
    logic                 grant_found;
    logic [IDX_W-1:0]     grant_idx;
    logic                 grant_valid;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;
    logic                 tmo_hit;
    logic [ENTRY_W-1:0]   wr_entry;
    logic [ENTRY_W-1:0]   head_entry;

    assign fifo_full   = (count_q == FULL_LVL);
    assign fifo_empty  = (count_q == '0);
    // Reset and flush both suppress acceptance so no request is acked and then lost.
    assign grant_valid = grant_found && !fifo_full && !flush && !sys_rst;
    assign head_entry  = fifo_mem_q[rd_ptr_q];

    // Round-robin search: first eligible channel after the last granted one, with wrap.
    always_comb begin
        eligible    = ch_req & ch_mask;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W + 1)'(i);
            if (cand >= NUM_CH_W) begin
                cand = cand - NUM_CH_W;
            end
            if (!grant_found && eligible[cand[IDX_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // One-hot accept strobe and the packed entry of the granted channel.
    always_comb begin
        ch_ack = '0;
        if (grant_valid) begin
            ch_ack[grant_idx] = 1'b1;
        end
        wr_entry = {ch_ascii[grant_idx*7 +: 7],
                    ch_start_x[grant_idx*X_W +: X_W],
                    ch_start_y[grant_idx*Y_W +: Y_W],
                    ch_en_size[grant_idx],
                    ch_front_color[grant_idx*COLOR_W +: COLOR_W],
                    ch_background_color[grant_idx*COLOR_W +: COLOR_W]};
    end

`ifdef CHAR_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

    assign tmo_hit = (state_q == ST_WAIT) && !lcd.show_char_done &&
                     (tmo_cnt_q == TMO_W'(TIMEOUT_CYC));

    // Count WAIT cycles; any exit from WAIT clears the count for the next request.
    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == ST_WAIT && !lcd.show_char_done && !tmo_hit) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign timeout_err = tmo_hit;
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Issue FSM: pop the head into the output fields, flag it, then wait for done.
    always_comb begin
        state_d  = state_q;
        issued_d = issued_q;
        pop      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && init_done && !flush) begin
                    pop      = 1'b1;
                    issued_d = head_entry;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = lcd.show_char_done ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                if (lcd.show_char_done || tmo_hit) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO pointers, level and RR pointer; flush empties the queue but leaves RR alone.
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rr_ptr_d   = rr_ptr_q;
        count_d    = count_q;
        if (grant_valid) begin
            fifo_mem_d[wr_ptr_q] = wr_entry;
            wr_ptr_d             = wr_ptr_q + 1'b1;
            rr_ptr_d             = grant_idx;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            count_d = count_q + LVL_W'(grant_valid) - LVL_W'(pop);
        end
    end

    // State registers with synchronous reset back to an empty, idle arbiter.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= RR_RESET;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            issued_q   <= '0;
            fifo_mem_q <= '{default: '0};
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            issued_q   <= issued_d;
            fifo_mem_q <= fifo_mem_d;
        end
    end

    assign lcd.show_char_flag   = (state_q == ST_ISSUE);
    assign lcd.ascii_num        = issued_q[ENTRY_W-1 -: 7];
    assign lcd.start_x          = issued_q[ENTRY_W-8 -: X_W];
    assign lcd.start_y          = issued_q[ENTRY_W-8-X_W -: Y_W];
    assign lcd.en_size          = issued_q[2*COLOR_W];
    assign lcd.front_color      = issued_q[2*COLOR_W-1 -: COLOR_W];
    assign lcd.background_color = issued_q[COLOR_W-1:0];

    assign fifo_level = count_q;
    assign busy       = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_char_req_arbiter.sv
// Directed self-checking bench for char_req_arbiter. Each scenario task
// drives its own stimulus and compares against hand-computed values.
// A small responder can answer show_char_flag with show_char_done after a
// programmable delay; a monitor logs every issued character.
module tb_char_req_arbiter;
    localparam int NUM_CH      = 4;
    localparam int FIFO_DEPTH  = 8;
    localparam int X_W         = 9;
    localparam int Y_W         = 9;
    localparam int COLOR_W     = 16;
    localparam int TIMEOUT_CYC = 100;

    logic                        sys_clk = 1'b0;
    logic                        sys_rst = 1'b1;
    logic                        init_done = 1'b0;
    logic [NUM_CH-1:0]           ch_mask = '1;
    logic [NUM_CH-1:0]           ch_req = '0;
    logic [NUM_CH-1:0]           ch_ack;
    logic [NUM_CH*7-1:0]         ch_ascii = '0;
    logic [NUM_CH*X_W-1:0]       ch_start_x = '0;
    logic [NUM_CH*Y_W-1:0]       ch_start_y = '0;
    logic [NUM_CH-1:0]           ch_en_size = '0;
    logic [NUM_CH*COLOR_W-1:0]   ch_front_color = '0;
    logic [NUM_CH*COLOR_W-1:0]   ch_background_color = '0;
    logic                        flush = 1'b0;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    logic                        busy;
    logic                        timeout_err;

    logic man_done = 1'b0;
    logic auto_pulse = 1'b0;
    bit   auto_done_en = 1'b0;
    int   done_delay = 1;

    int         checks = 0;
    int         failures = 0;
    logic [6:0] flag_log [$];
    int         tmo_pulses = 0;

    char_req_arbiter_if #(.X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W)) lcd_if ();

    assign lcd_if.show_char_done = man_done | auto_pulse;

    char_req_arbiter #(
        .NUM_CH(NUM_CH), .FIFO_DEPTH(FIFO_DEPTH), .X_W(X_W), .Y_W(Y_W),
        .COLOR_W(COLOR_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .init_done(init_done),
        .ch_mask(ch_mask), .ch_req(ch_req), .ch_ack(ch_ack),
        .ch_ascii(ch_ascii), .ch_start_x(ch_start_x), .ch_start_y(ch_start_y),
        .ch_en_size(ch_en_size), .ch_front_color(ch_front_color),
        .ch_background_color(ch_background_color), .flush(flush),
        .lcd(lcd_if), .fifo_level(fifo_level), .busy(busy),
        .timeout_err(timeout_err)
    );

    always #5 sys_clk = ~sys_clk;

    // Log every issued character and every timeout pulse.
    initial begin
        forever begin
            @(negedge sys_clk);
            if (lcd_if.show_char_flag === 1'b1) flag_log.push_back(lcd_if.ascii_num);
            if (timeout_err === 1'b1) tmo_pulses++;
        end
    end

    // Answer each flag with a one-cycle done, done_delay cycles later.
    initial begin
        forever begin
            @(negedge sys_clk);
            if (auto_done_en && lcd_if.show_char_flag === 1'b1) begin
                repeat (done_delay) @(posedge sys_clk);
                #1 auto_pulse = 1'b1;
                @(posedge sys_clk);
                #1 auto_pulse = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog act=running exp=finished");
        $fatal(1, "[TB] simulation watchdog expired");
    end

    task automatic to_sample;
        @(negedge sys_clk);
    endtask

    task automatic to_next;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic set_defaults;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_ascii[i*7 +: 7]                        = 7'(8'h30 + i);
            ch_start_x[i*X_W +: X_W]                  = X_W'(i * 16);
            ch_start_y[i*Y_W +: Y_W]                  = Y_W'(i * 12);
            ch_en_size[i]                             = 1'b0;
            ch_front_color[i*COLOR_W +: COLOR_W]      = COLOR_W'(16'h1111 * i);
            ch_background_color[i*COLOR_W +: COLOR_W] = COLOR_W'(16'h0F0F + i);
        end
    endtask

    task automatic do_reset;
        sys_rst      = 1'b1;
        ch_req       = '0;
        ch_mask      = '1;
        flush        = 1'b0;
        man_done     = 1'b0;
        auto_done_en = 1'b0;
        init_done    = 1'b1;
        set_defaults();
        to_next();
        to_next();
        sys_rst = 1'b0;
    endtask

    task automatic test_reset;
        sys_rst = 1'b1;
        init_done = 1'b1;
        ch_req = 4'b1111;
        to_next();
        to_sample();
        checks++; if (ch_ack !== 4'b0000) begin failures++; $display("[TB] FAIL reset_ack act=%b exp=0000", ch_ack); end
        checks++; if (lcd_if.show_char_flag !== 1'b0) begin failures++; $display("[TB] FAIL reset_flag act=%b exp=0", lcd_if.show_char_flag); end
        checks++; if (fifo_level !== 4'd0) begin failures++; $display("[TB] FAIL reset_level act=%0d exp=0", fifo_level); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy act=%b exp=0", busy); end
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_tmo act=%b exp=0", timeout_err); end
        checks++; if (lcd_if.ascii_num !== 7'h00 || lcd_if.front_color !== 16'h0000) begin failures++; $display("[TB] FAIL reset_fields act=%h/%h exp=00/0000", lcd_if.ascii_num, lcd_if.front_color); end
        ch_req = '0;
        to_next();
        sys_rst = 1'b0;
    endtask

    task automatic test_single_request;
        do_reset();
        ch_ascii[13:7] = 7'h41;
        ch_start_x[17:9] = 9'd10;
        ch_start_y[17:9] = 9'd20;
        ch_en_size[1] = 1'b1;
        ch_front_color[31:16] = 16'hF800;
        ch_background_color[31:16] = 16'h0000;
        ch_req = 4'b0010;
        to_sample();
        checks++; if (ch_ack !== 4'b0010) begin failures++; $display("[TB] FAIL single_ack act=%b exp=0010", ch_ack); end
        to_next();
        ch_req = '0;
        to_sample();
        checks++; if (lcd_if.show_char_flag !== 1'b0 || fifo_level !== 4'd1) begin failures++; $display("[TB] FAIL single_n1 act=flag%b/lvl%0d exp=flag0/lvl1", lcd_if.show_char_flag, fifo_level); end
        to_next();
        to_sample();
        checks++; if (lcd_if.show_char_flag !== 1'b1) begin failures++; $display("[TB] FAIL single_flag act=%b exp=1", lcd_if.show_char_flag); end
        checks++; if (lcd_if.ascii_num !== 7'h41 || lcd_if.start_x !== 9'd10 || lcd_if.start_y !== 9'd20) begin failures++; $display("[TB] FAIL single_pos act=%h,%0d,%0d exp=41,10,20", lcd_if.ascii_num, lcd_if.start_x, lcd_if.start_y); end
        checks++; if (lcd_if.en_size !== 1'b1 || lcd_if.front_color !== 16'hF800 || lcd_if.background_color !== 16'h0000) begin failures++; $display("[TB] FAIL single_color act=%b,%h,%h exp=1,f800,0000", lcd_if.en_size, lcd_if.front_color, lcd_if.background_color); end
        to_next();
        to_sample();
        checks++; if (lcd_if.show_char_flag !== 1'b0) begin failures++; $display("[TB] FAIL single_pulse act=%b exp=0", lcd_if.show_char_flag); end
        repeat (4) to_next();
        man_done = 1'b1;
        to_sample();
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL single_busy_done act=%b exp=1", busy); end
        to_next();
        man_done = 1'b0;
        to_sample();
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL single_busy_after act=%b exp=0", busy); end
        checks++; if (lcd_if.ascii_num !== 7'h41) begin failures++; $display("[TB] FAIL single_stable act=%h exp=41", lcd_if.ascii_num); end
        to_next();
    endtask

    task automatic test_round_robin;
        int base;
        logic [NUM_CH-1:0] exp_ack;
        logic [6:0] exp_ascii;
        do_reset();
        auto_done_en = 1'b1;
        done_delay = 1;
        base = flag_log.size();
        ch_req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            to_sample();
            exp_ack = 4'(1 << (k % 4));
            checks++; if (ch_ack !== exp_ack) begin failures++; $display("[TB] FAIL rr_ack%0d act=%b exp=%b", k, ch_ack, exp_ack); end
            to_next();
        end
        ch_req = '0;
        for (int c = 0; c < 200 && (flag_log.size() < base + 5 || busy); c++) to_next();
        checks++; if (flag_log.size() - base !== 5) begin failures++; $display("[TB] FAIL rr_flag_count act=%0d exp=5", flag_log.size() - base); end
        for (int i = 0; i < 5 && base + i < flag_log.size(); i++) begin
            exp_ascii = 7'(8'h30 + (i % 4));
            checks++; if (flag_log[base+i] !== exp_ascii) begin failures++; $display("[TB] FAIL rr_order%0d act=%h exp=%h", i, flag_log[base+i], exp_ascii); end
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rr_idle act=%b exp=0", busy); end
        auto_done_en = 1'b0;
    endtask

    task automatic test_init_hold;
        int base;
        int acks;
        int bad;
        do_reset();
        init_done = 1'b0;
        auto_done_en = 1'b1;
        done_delay = 2;
        base = flag_log.size();
        acks = 0;
        ch_req = 4'b0100;
        for (int k = 0; k < 10; k++) begin
            to_sample();
            if (ch_ack[2] === 1'b1) acks++;
            to_next();
        end
        to_sample();
        checks++; if (acks !== 8) begin failures++; $display("[TB] FAIL hold_acks act=%0d exp=8", acks); end
        checks++; if (fifo_level !== 4'd8) begin failures++; $display("[TB] FAIL hold_level act=%0d exp=8", fifo_level); end
        checks++; if (ch_ack !== 4'b0000) begin failures++; $display("[TB] FAIL hold_full_ack act=%b exp=0000", ch_ack); end
        checks++; if (flag_log.size() - base !== 0) begin failures++; $display("[TB] FAIL hold_noflag act=%0d exp=0", flag_log.size() - base); end
        to_next();
        init_done = 1'b1;
        for (int c = 0; c < 300 && acks < 10; c++) begin
            to_sample();
            if (ch_ack[2] === 1'b1) acks++;
            to_next();
        end
        ch_req = '0;
        for (int c = 0; c < 300 && (flag_log.size() < base + 10 || busy); c++) to_next();
        checks++; if (acks !== 10) begin failures++; $display("[TB] FAIL hold_total_acks act=%0d exp=10", acks); end
        checks++; if (flag_log.size() - base !== 10) begin failures++; $display("[TB] FAIL hold_flags act=%0d exp=10", flag_log.size() - base); end
        bad = 0;
        for (int i = base; i < flag_log.size(); i++) if (flag_log[i] !== 7'h32) bad++;
        checks++; if (bad !== 0) begin failures++; $display("[TB] FAIL hold_ascii act=%0d_wrong exp=0_wrong", bad); end
        checks++; if (fifo_level !== 4'd0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL hold_drain act=lvl%0d/busy%b exp=lvl0/busy0", fifo_level, busy); end
        auto_done_en = 1'b0;
    endtask

    task automatic test_flush;
        int base;
        do_reset();
        base = flag_log.size();
        ch_req = 4'b1000;
        for (int k = 0; k < 5; k++) begin
            to_sample();
            checks++; if (ch_ack !== 4'b1000) begin failures++; $display("[TB] FAIL flush_fill%0d act=%b exp=1000", k, ch_ack); end
            to_next();
        end
        ch_req = 4'b0001;
        flush = 1'b1;
        to_sample();
        checks++; if (fifo_level !== 4'd4) begin failures++; $display("[TB] FAIL flush_pre_level act=%0d exp=4", fifo_level); end
        checks++; if (ch_ack !== 4'b0000) begin failures++; $display("[TB] FAIL flush_noack act=%b exp=0000", ch_ack); end
        to_next();
        flush = 1'b0;
        ch_req = '0;
        to_sample();
        checks++; if (fifo_level !== 4'd0) begin failures++; $display("[TB] FAIL flush_level act=%0d exp=0", fifo_level); end
        checks++; if (busy !== 1'b1 || lcd_if.show_char_flag !== 1'b0) begin failures++; $display("[TB] FAIL flush_inflight act=busy%b/flag%b exp=busy1/flag0", busy, lcd_if.show_char_flag); end
        to_next();
        man_done = 1'b1;
        to_next();
        man_done = 1'b0;
        to_sample();
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL flush_done_idle act=%b exp=0", busy); end
        repeat (10) to_next();
        checks++; if (flag_log.size() - base !== 1) begin failures++; $display("[TB] FAIL flush_flags act=%0d exp=1", flag_log.size() - base); end
    endtask

    task automatic test_mask;
        int base;
        int ch2_acks;
        int seq [6] = '{0, 1, 3, 0, 1, 3};
        logic [NUM_CH-1:0] exp_ack;
        do_reset();
        ch_mask = 4'b1011;
        auto_done_en = 1'b1;
        done_delay = 1;
        base = flag_log.size();
        ch2_acks = 0;
        ch_req = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            to_sample();
            exp_ack = 4'(1 << seq[k]);
            if (ch_ack[2] === 1'b1) ch2_acks++;
            checks++; if (ch_ack !== exp_ack) begin failures++; $display("[TB] FAIL mask_ack%0d act=%b exp=%b", k, ch_ack, exp_ack); end
            to_next();
        end
        ch_req = '0;
        for (int c = 0; c < 200 && (flag_log.size() < base + 6 || busy); c++) to_next();
        checks++; if (ch2_acks !== 0) begin failures++; $display("[TB] FAIL mask_ch2 act=%0d exp=0", ch2_acks); end
        checks++; if (flag_log.size() - base !== 6) begin failures++; $display("[TB] FAIL mask_flags act=%0d exp=6", flag_log.size() - base); end
        auto_done_en = 1'b0;
        ch_mask = '1;
    endtask

`ifdef CHAR_ARB_TIMEOUT_EN
    task automatic test_timeout;
        int tbase;
        int tmo_at;
        int flag_at;
        do_reset();
        tbase = tmo_pulses;
        tmo_at = -1;
        flag_at = -1;
        ch_req = 4'b0001;
        to_sample();
        checks++; if (ch_ack !== 4'b0001) begin failures++; $display("[TB] FAIL tmo_ack0 act=%b exp=0001", ch_ack); end
        to_next();
        ch_req = 4'b0010;
        to_sample();
        checks++; if (ch_ack !== 4'b0010) begin failures++; $display("[TB] FAIL tmo_ack1 act=%b exp=0010", ch_ack); end
        to_next();
        ch_req = '0;
        to_sample();
        checks++; if (lcd_if.show_char_flag !== 1'b1) begin failures++; $display("[TB] FAIL tmo_first_flag act=%b exp=1", lcd_if.show_char_flag); end
        to_next();
        for (int k = 0; k < 200; k++) begin
            to_sample();
            if (timeout_err === 1'b1 && tmo_at < 0) tmo_at = k;
            if (lcd_if.show_char_flag === 1'b1 && flag_at < 0) flag_at = k;
            to_next();
        end
        checks++; if (tmo_at !== 100) begin failures++; $display("[TB] FAIL tmo_pulse_cycle act=%0d exp=100", tmo_at); end
        checks++; if (flag_at !== 102) begin failures++; $display("[TB] FAIL tmo_next_flag act=%0d exp=102", flag_at); end
        checks++; if (tmo_pulses - tbase !== 1) begin failures++; $display("[TB] FAIL tmo_pulse_count act=%0d exp=1", tmo_pulses - tbase); end
        checks++; if (lcd_if.ascii_num !== 7'h31) begin failures++; $display("[TB] FAIL tmo_second_ascii act=%h exp=31", lcd_if.ascii_num); end
    endtask
`endif

    task automatic test_midway_reset;
        int tbase;
`ifdef CHAR_ARB_TIMEOUT_EN
        int wait_n = 20;
`else
        int wait_n = 150;
`endif
        do_reset();
        ch_req = 4'b0001;
        repeat (3) to_next();
        ch_req = '0;
        tbase = tmo_pulses;
        repeat (wait_n) to_next();
        to_sample();
        checks++; if (fifo_level !== 4'd2) begin failures++; $display("[TB] FAIL mid_level act=%0d exp=2", fifo_level); end
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL mid_busy act=%b exp=1", busy); end
        checks++; if (tmo_pulses - tbase !== 0) begin failures++; $display("[TB] FAIL mid_no_tmo act=%0d exp=0", tmo_pulses - tbase); end
        to_next();
        sys_rst = 1'b1;
        to_next();
        to_sample();
        checks++; if (fifo_level !== 4'd0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_state act=lvl%0d/busy%b exp=lvl0/busy0", fifo_level, busy); end
        checks++; if (lcd_if.ascii_num !== 7'h00 || lcd_if.show_char_flag !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_out act=%h/%b exp=00/0", lcd_if.ascii_num, lcd_if.show_char_flag); end
        to_next();
        sys_rst = 1'b0;
    endtask

    initial begin
        $display("[TB] char_req_arbiter directed bench start");
        test_reset();
        test_single_request();
        test_round_robin();
        test_init_hold();
        test_flush();
        test_mask();
`ifdef CHAR_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_midway_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
